// File: rtl/bk_pkg.sv
// Shared types and constants for the breakdown-test pulse generator.
// Defaults assume the 25 MHz system clock.
package bk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bk_state_e;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   // 876 clocks high (~35 us) every 500001 clocks (~20 ms)
   localparam int unsigned C_BK_HIGH_DEF   = 876;
   localparam int unsigned C_BK_PERIOD_DEF = 500001;

endpackage

// File: rtl/bk_ch_window.sv
// Per-channel pulse window: high while offset <= cnt < offset + high.
// The sum is one bit wider, so a large offset+high cannot alias to a small value.
module bk_ch_window
   import bk_pkg::*;
#(
   parameter int CNT_W = 19
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] offset,
   input  logic [CNT_W-1:0] high,
   output logic             win
);

   logic [CNT_W:0] win_end;

   assign win_end = {1'b0, offset} + {1'b0, high};
   assign win     = (cnt >= offset) && ({1'b0, cnt} < win_end);

endmodule

// File: rtl/bk_pulse_gen_nch.sv
// Multi-channel breakdown-test pulse generator: staggered per-channel pulses,
// continuous or counted-burst mode, live channel mask, start/stop control.
module bk_pulse_gen_nch
   import bk_pkg::*;
#(
   parameter int CH_NUM  = 6,
   parameter int CNT_W   = 19,
   parameter int BURST_W = 8,
   parameter int STAGGER = 0
) (
   input  logic               i_clk_25m,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_mode,
   input  logic [BURST_W-1:0] i_burst_num,
   input  logic [CNT_W-1:0]   i_high_cyc,
   input  logic [CNT_W-1:0]   i_period_cyc,
   input  logic [CH_NUM-1:0]  i_ch_en,
   output logic [CH_NUM-1:0]  o_bk_pulse,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_cfg_err,
   output bk_state_e          o_fsm_state
);

   // Start/stop handshake: i_start is a level request sampled only in IDLE; it is
   // accepted (IDLE->RUN, config latched) when i_stop=0 and the config is valid,
   // otherwise answered by a one-cycle o_cfg_err. i_stop always wins and needs
   // no acknowledge: it forces IDLE on the next edge. o_busy mirrors RUN.
   localparam int unsigned OFS_SPAN = (CH_NUM - 1) * STAGGER;

   bk_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [BURST_W-1:0]   pcnt_q;
   logic                 mode_q;
   logic [BURST_W-1:0]   burst_q;
   logic [CNT_W-1:0]     high_q;
   logic [CNT_W-1:0]     period_q;
   logic                 err_q;
   logic [CH_NUM-1:0]    pulse_q;
   logic [CH_NUM-1:0]    win;

   logic [CNT_W:0]       need_len;
   logic                 cfg_ok;
   logic                 start_req;
   logic                 start_go;
   logic                 start_bad;
   logic                 wrap;
   logic                 last_period;
   logic                 run_hold;

   // Last channel's window must end inside the period so no window wraps.
   assign need_len    = (CNT_W+1)'(OFS_SPAN) + {1'b0, i_high_cyc};
   assign cfg_ok      = (i_high_cyc != '0)
                     && (need_len <= {1'b0, i_period_cyc})
                     && (i_period_cyc >= CNT_W'(2))
                     && ((i_mode == MODE_CONT) || (i_burst_num != '0));

   assign start_req   = (state_q == ST_IDLE) && i_start && !i_stop;
   assign start_go    = start_req && cfg_ok;
   assign start_bad   = start_req && !cfg_ok;

   assign wrap        = (cnt_q == (period_q - CNT_W'(1)));
   assign last_period = (mode_q == MODE_BURST) && ((pcnt_q + BURST_W'(1)) == burst_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_go) state_d = ST_RUN;
         ST_RUN: begin
            if (i_stop)                    state_d = ST_IDLE;
            else if (wrap && last_period)  state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Outputs only drive while RUN continues past this edge, so stop/DONE edges are low.
   assign run_hold = (state_q == ST_RUN) && (state_d == ST_RUN);

   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      bk_ch_window #(.CNT_W(CNT_W)) u_win (
         .cnt    (cnt_q),
         .offset (CNT_W'(k * STAGGER)),
         .high   (high_q),
         .win    (win[k])
      );
   end

   always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         pcnt_q   <= '0;
         mode_q   <= MODE_CONT;
         burst_q  <= '0;
         high_q   <= '0;
         period_q <= '0;
         err_q    <= 1'b0;
         pulse_q  <= '0;
      end else begin
         err_q <= start_bad;
         if (start_go) begin
            mode_q   <= i_mode;
            burst_q  <= i_burst_num;
            high_q   <= i_high_cyc;
            period_q <= i_period_cyc;
            cnt_q    <= '0;
            pcnt_q   <= '0;
         end else if (run_hold) begin
            if (wrap) begin
               cnt_q  <= '0;
               pcnt_q <= pcnt_q + BURST_W'(1);
            end else begin
               cnt_q  <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q  <= '0;
            pcnt_q <= '0;
         end
         pulse_q <= run_hold ? (win & i_ch_en) : '0;
      end
   end

   assign o_bk_pulse  = pulse_q;
   assign o_busy      = (state_q == ST_RUN);
   assign o_done      = (state_q == ST_DONE);
   assign o_cfg_err   = err_q;
   assign o_fsm_state = state_q;

endmodule

// File: tb/tb_bk_pulse_gen_nch.sv
// Bench for bk_pulse_gen_nch: one instance with STAGGER=0 (index 0) and one with
// STAGGER=10 (index 1), checked every cycle against a closed-form pulse model.
module tb_bk_pulse_gen_nch;
   import bk_pkg::*;

   localparam int CH = 6;
   localparam int CW = 19;
   localparam int BW = 8;

   typedef struct packed {
      logic [CH-1:0] pulse;
      logic          busy;
      logic          done;
      logic          err;
      logic [1:0]    st;
   } obs_t;
   localparam int OW = $bits(obs_t);

   typedef struct {
      int          sel;
      logic        mode;
      int          burst;
      int          high;
      int          period;
      logic [CH-1:0] en;
      bit          valid;
      int          ncyc;
      bit          hold_start;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #20 clk = ~clk;

   logic          start [2];
   logic          stop  [2];
   logic          mode  [2];
   logic [BW-1:0] burst [2];
   logic [CW-1:0] high  [2];
   logic [CW-1:0] period[2];
   logic [CH-1:0] en    [2];
   logic [CH-1:0] pulse [2];
   logic          busy  [2];
   logic          done  [2];
   logic          err   [2];
   bk_state_e     st    [2];

   bk_pulse_gen_nch #(.CH_NUM(CH), .CNT_W(CW), .BURST_W(BW), .STAGGER(0)) u_dut_s0 (
      .i_clk_25m(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_stop(stop[0]),
      .i_mode(mode[0]), .i_burst_num(burst[0]), .i_high_cyc(high[0]),
      .i_period_cyc(period[0]), .i_ch_en(en[0]), .o_bk_pulse(pulse[0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_cfg_err(err[0]), .o_fsm_state(st[0])
   );

   bk_pulse_gen_nch #(.CH_NUM(CH), .CNT_W(CW), .BURST_W(BW), .STAGGER(10)) u_dut_s10 (
      .i_clk_25m(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_stop(stop[1]),
      .i_mode(mode[1]), .i_burst_num(burst[1]), .i_high_cyc(high[1]),
      .i_period_cyc(period[1]), .i_ch_en(en[1]), .o_bk_pulse(pulse[1]),
      .o_busy(busy[1]), .o_done(done[1]), .o_cfg_err(err[1]), .o_fsm_state(st[1])
   );

   // ---------------- scoreboard ----------------
   logic [OW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   function automatic obs_t get_obs(int s);
      obs_t o;
      o.pulse = pulse[s];
      o.busy  = busy[s];
      o.done  = done[s];
      o.err   = err[s];
      o.st    = st[s];
      return o;
   endfunction

   function automatic obs_t mk_obs(logic [CH-1:0] p, logic b, logic d, logic e, logic [1:0] s);
      obs_t o;
      o.pulse = p; o.busy = b; o.done = d; o.err = e; o.st = s;
      return o;
   endfunction

   task automatic sb_check(string nm, int s);
      logic [OW-1:0] exp_v;
      logic [OW-1:0] act_v;
      act_v = get_obs(s);
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard empty act=%h", nm, act_v);
      end else begin
         exp_v = exp_q.pop_front();
         if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s act(pulse,busy,done,err,st)=%h required=%h", nm, act_v, exp_v);
         end
      end
   endtask

   // Expected outputs in cycle T+c for a start accepted/rejected at edge T.
   function automatic obs_t model(vec_t v, int c);
      obs_t e;
      int stg, tot, ph;
      e   = '0;
      stg = (v.sel == 1) ? 10 : 0;
      if (!v.valid) begin
         e.err = (c == 1);
         return e;
      end
      tot = v.mode ? v.burst * v.period : 32'h3fff_ffff;
      if (c <= tot) begin
         e.busy = 1'b1;
         e.st   = ST_RUN;
         if (c >= 2) begin
            ph = (c - 2) % v.period;
            for (int k = 0; k < CH; k++)
               e.pulse[k] = v.en[k] && (ph >= k * stg) && (ph < k * stg + v.high);
         end
      end else if (c == tot + 1) begin
         e.done = 1'b1;
         e.st   = ST_DONE;
      end
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_cfg(int s, logic md, int b, int h, int p, logic [CH-1:0] m);
      mode[s]   = md;
      burst[s]  = BW'(b);
      high[s]   = CW'(h);
      period[s] = CW'(p);
      en[s]     = m;
   endtask

   task automatic run_vec(int idx, vec_t v);
      int s, n;
      s = v.sel;
      if (!v.valid)     n = 8;
      else if (v.mode)  n = v.burst * v.period + 3;
      else              n = v.ncyc;
      set_cfg(s, v.mode, v.burst, v.high, v.period, v.en);
      stop[s]  = 1'b0;
      start[s] = 1'b1;
      for (int c = 1; c <= n; c++) begin
         exp_q.push_back(model(v, c));
         @(negedge clk);
         sb_check($sformatf("vec%0d_c%0d", idx, c), s);
         if (!v.hold_start) start[s] = 1'b0;
         if (c == 1 && v.valid) begin
            // config scrambled while running must not matter
            mode[s]   = 1'($urandom_range(0, 1));
            burst[s]  = BW'($urandom_range(0, 3));
            high[s]   = CW'($urandom_range(0, 1000));
            period[s] = CW'($urandom_range(0, 100));
         end
      end
      if (v.valid && !v.mode) begin
         start[s] = 1'b0;
         stop[s]  = 1'b1;
         exp_q.push_back('0);
         @(negedge clk);
         sb_check($sformatf("vec%0d_stop", idx), s);
         stop[s] = 1'b0;
      end
      start[s] = 1'b0;
   endtask

   function automatic vec_t mk(int sel, logic md, int b, int h, int p, logic [CH-1:0] m,
                               bit ok, int n, bit hs);
      vec_t v;
      v.sel = sel; v.mode = md; v.burst = b; v.high = h; v.period = p;
      v.en = m; v.valid = ok; v.ncyc = n; v.hold_start = hs;
      return v;
   endfunction

   vec_t vecs[11];

   initial begin
      for (int s = 0; s < 2; s++) begin
         start[s] = 1'b0; stop[s] = 1'b0;
         set_cfg(s, MODE_CONT, 0, 0, 0, 6'h3F);
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         exp_q.push_back('0);
         sb_check($sformatf("reset_s%0d", s), s);
      end
      rst_n = 1'b1;
      @(negedge clk);

      vecs[0]  = mk(0, MODE_CONT,  0, C_BK_HIGH_DEF, C_BK_PERIOD_DEF, 6'h3F, 1, 900, 0);
      vecs[1]  = mk(1, MODE_BURST, 3, 4,   80, 6'h3F, 1, 0,   0);
      vecs[2]  = mk(1, MODE_CONT,  0, 40,  80, 6'h3F, 0, 0,   0);
      vecs[3]  = mk(1, MODE_BURST, 0, 4,   80, 6'h3F, 0, 0,   0);
      vecs[4]  = mk(0, MODE_CONT,  0, 0,   10, 6'h3F, 0, 0,   0);
      vecs[5]  = mk(0, MODE_CONT,  0, 1,   1,  6'h3F, 0, 0,   0);
      vecs[6]  = mk(1, MODE_BURST, 2, 30,  80, 6'h3F, 1, 0,   0);
      vecs[7]  = mk(0, MODE_BURST, 4, 2,   2,  6'h3F, 1, 0,   0);
      vecs[8]  = mk(1, MODE_CONT,  0, 5,   60, 6'h15, 1, 130, 1);
      vecs[9]  = mk(0, MODE_BURST, 1, 3,   5,  6'h2A, 1, 0,   0);
      vecs[10] = mk(1, MODE_CONT,  0, 31,  80, 6'h3F, 0, 0,   0);
      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Live mask: drop ch2 while pulses are high, then re-enable.
      set_cfg(0, MODE_CONT, 0, 20, 80, 6'h3F);
      start[0] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         if (c < 2)                exp_q.push_back(mk_obs(6'h00, 1, 0, 0, ST_RUN));
         else if (c == 7 || c == 8) exp_q.push_back(mk_obs(6'h3B, 1, 0, 0, ST_RUN));
         else                      exp_q.push_back(mk_obs(6'h3F, 1, 0, 0, ST_RUN));
         @(negedge clk);
         sb_check($sformatf("mask_c%0d", c), 0);
         start[0] = 1'b0;
         if (c == 6) en[0] = 6'h3B;
         if (c == 8) en[0] = 6'h3F;
      end
      stop[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         exp_q.push_back('0);
         @(negedge clk);
         sb_check($sformatf("stop_c%0d", c), 0);
         stop[0] = 1'b0;
      end

      // Start and stop together in IDLE: nothing happens, even with a bad config.
      for (int h = 0; h < 2; h++) begin
         set_cfg(0, MODE_CONT, 0, (h == 0) ? 20 : 0, 80, 6'h3F);
         start[0] = 1'b1;
         stop[0]  = 1'b1;
         for (int c = 0; c < 4; c++) begin
            exp_q.push_back('0);
            @(negedge clk);
            sb_check($sformatf("startstop%0d_c%0d", h, c), 0);
            start[0] = 1'b0;
            stop[0]  = 1'b0;
         end
      end

      // Asynchronous reset in the middle of a pulse.
      set_cfg(0, MODE_CONT, 0, 20, 80, 6'h3F);
      start[0] = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         exp_q.push_back(mk_obs((c >= 2) ? 6'h3F : 6'h00, 1, 0, 0, ST_RUN));
         @(negedge clk);
         sb_check($sformatf("prerst_c%0d", c), 0);
         start[0] = 1'b0;
      end
      #5 rst_n = 1'b0;
      #1;
      exp_q.push_back('0);
      sb_check("rst_async_drop", 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         exp_q.push_back('0);
         @(negedge clk);
         sb_check($sformatf("postrst_c%0d", c), 0);
      end
      start[0] = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         exp_q.push_back(mk_obs((c >= 2) ? 6'h3F : 6'h00, 1, 0, 0, ST_RUN));
         @(negedge clk);
         sb_check($sformatf("restart_c%0d", c), 0);
         start[0] = 1'b0;
      end
      stop[0] = 1'b1;
      exp_q.push_back('0);
      @(negedge clk);
      sb_check("restart_stop", 0);
      stop[0] = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
